cga_vram_arbiter: RTL and testbench

Shares the single CGA/Tandy video RAM port between the display fetch path (character/attribute/pixel reads issued by the sequencer) and CPU memory cycles arriving from the ISA bus. Display fetches always have priority. The CPU is granted the RAM only in the sequencer's ISA slots, and bus_rdy is held low until its access completes. Sits between the ISA bus interface, the sequencer/pixel pipeline and the external RAM.

---
 rtl/cga_vram_arbiter.sv | 144 ++++++++++++++
 tb/tb_cga_vram_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cga_vram_arbiter.sv
// Shares the CGA/Tandy video RAM between display fetches (always first) and ISA CPU cycles.
// Optional CGA_SNOW_EN: CPU takes the RAM at once and corrupts disp_d, reproducing CGA snow.
module cga_vram_arbiter #(
  parameter int USE_BUS_WAIT = 1,
  parameter int MAX_WAIT     = 31,
  parameter int CPU_AW       = 15
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              mem_cs,
  input  logic [CPU_AW-1:0] bus_a,
  input  logic [7:0]        bus_d,
  input  logic              bus_memr_l,
  input  logic              bus_memw_l,
  output logic              bus_rdy,
  output logic [7:0]        cpu_rd_data,
  input  logic [18:0]       disp_a,
  input  logic              disp_read,
  input  logic              isa_op_enable,
  output logic [18:0]       ram_a,
  output logic              ram_we_l,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_d,
  output logic [7:0]        disp_d,
  output logic [2:0]        o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_SLOT = 3'd1,
    S_ACCESS    = 3'd2,
    S_CAPTURE   = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_memr_s1, r_memr_s2;
  logic              r_memw_s1, r_memw_s2;
  logic [CPU_AW-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic              r_is_wr;
  logic [4:0]        r_wait_cnt;
  logic              w_start;
  logic              w_req_act;
  logic              w_busy;
  logic              w_cpu_we;

  // Strobes come straight off the ISA bus; two flops before any decision.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_memr_s1 <= 1'b1;
      r_memr_s2 <= 1'b1;
      r_memw_s1 <= 1'b1;
      r_memw_s2 <= 1'b1;
    end else begin
      r_memr_s1 <= bus_memr_l;
      r_memr_s2 <= r_memr_s1;
      r_memw_s1 <= bus_memw_l;
      r_memw_s2 <= r_memw_s1;
    end
  end

  assign w_start   = (r_state == S_IDLE) && mem_cs && (!r_memr_s2 || !r_memw_s2);
  // The strobe that opened the cycle decides abort and completion.
  assign w_req_act = r_is_wr ? !r_memw_s2 : !r_memr_s2;
  assign w_busy    = (r_state == S_WAIT_SLOT) || (r_state == S_ACCESS) || (r_state == S_CAPTURE);
  assign w_cpu_we  = (r_state == S_ACCESS) && r_is_wr;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_wdata     <= 8'h00;
      r_is_wr     <= 1'b0;
      r_wait_cnt  <= 5'd0;
      cpu_rd_data <= 8'h00;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_addr  <= bus_a;
        r_wdata <= bus_d;
        r_is_wr <= !r_memw_s2;
      end
      if (r_state == S_WAIT_SLOT) begin
        if (r_wait_cnt != 5'h1f) r_wait_cnt <= r_wait_cnt + 5'd1;
      end else begin
        r_wait_cnt <= 5'd0;
      end
      if ((r_state == S_CAPTURE) && !r_is_wr) cpu_rd_data <= ram_d;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (w_start) w_state_next = S_WAIT_SLOT;
      S_WAIT_SLOT: begin
        if (!w_req_act) begin
          w_state_next = S_IDLE;
`ifdef CGA_SNOW_EN
        end else begin
          w_state_next = S_ACCESS;
`else
        end else if ((isa_op_enable || (r_wait_cnt == 5'(MAX_WAIT))) && !disp_read) begin
          w_state_next = S_ACCESS;
`endif
        end
      end
      S_ACCESS:    w_state_next = S_CAPTURE;
      S_CAPTURE:   w_state_next = S_DONE;
      S_DONE:      if (!w_req_act) w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  assign ram_a       = (r_state == S_ACCESS) ? {{(19-CPU_AW){1'b0}}, r_addr} : disp_a;
  assign ram_we_l    = !w_cpu_we;
  assign ram_dout    = w_cpu_we ? r_wdata : 8'h00;
  assign o_dbg_state = r_state;

  generate
    if (USE_BUS_WAIT != 0) begin : g_bus_wait
      assign bus_rdy = !(w_start || w_busy);
    end else begin : g_no_wait
      assign bus_rdy = 1'b1;
    end
  endgenerate

`ifdef CGA_SNOW_EN
  logic r_snow;

  // The display sampled the bus while the CPU drove it: it sees the CPU byte.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) r_snow <= 1'b0;
    else          r_snow <= (r_state == S_ACCESS) && disp_read;
  end

  assign disp_d = (r_snow && r_is_wr) ? r_wdata : ram_d;
`else
  assign disp_d = ram_d;
`endif

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Directed bench for cga_vram_arbiter: write, read, display priority, timeout, abort, reset, snow.
`timescale 1ns/1ps
module tb_cga_vram_arbiter;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAIT    = 3'd1;
  localparam logic [2:0] ST_ACCESS  = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  logic        clk;
  logic        reset_l;
  logic        mem_cs;
  logic [14:0] bus_a;
  logic [7:0]  bus_d;
  logic        bus_memr_l;
  logic        bus_memw_l;
  logic        bus_rdy;
  logic [7:0]  cpu_rd_data;
  logic [18:0] disp_a;
  logic        disp_read;
  logic        isa_op_enable;
  logic [18:0] ram_a;
  logic        ram_we_l;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_d;
  logic [7:0]  disp_d;
  logic [2:0]  o_dbg_state;

  int          n_total = 0;
  int          n_bad   = 0;
  int          we_cnt  = 0;
  logic [18:0] we_a    = '0;
  logic [7:0]  we_d    = '0;
  int          disp_bad = 0;

  cga_vram_arbiter dut (
    .clk(clk), .reset_l(reset_l), .mem_cs(mem_cs), .bus_a(bus_a), .bus_d(bus_d),
    .bus_memr_l(bus_memr_l), .bus_memw_l(bus_memw_l), .bus_rdy(bus_rdy),
    .cpu_rd_data(cpu_rd_data), .disp_a(disp_a), .disp_read(disp_read),
    .isa_op_enable(isa_op_enable), .ram_a(ram_a), .ram_we_l(ram_we_l),
    .ram_dout(ram_dout), .ram_d(ram_d), .disp_d(disp_d), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model with one cycle read latency; 0x1234 holds 3C
  always @(posedge clk)
    ram_d <= (ram_a == 19'h01234) ? 8'h3C : (ram_a[7:0] ^ 8'h5A);

  always @(negedge clk) begin
    if (ram_we_l === 1'b0) begin
      we_cnt = we_cnt + 1;
      we_a   = ram_a;
      we_d   = ram_dout;
    end
`ifndef CGA_SNOW_EN
    if (disp_d !== ram_d) disp_bad = disp_bad + 1;
`endif
  end

  task tick;
    @(negedge clk);
  endtask

  task test_reset;
    reset_l = 1'b0;
    tick; tick;
    n_total++; if (bus_rdy !== 1'b1) begin n_bad++; $display("FAIL rst_rdy got=%0h exp=1", bus_rdy); end
    n_total++; if (ram_we_l !== 1'b1) begin n_bad++; $display("FAIL rst_we got=%0h exp=1", ram_we_l); end
    n_total++; if (ram_dout !== 8'h00) begin n_bad++; $display("FAIL rst_dout got=%0h exp=0", ram_dout); end
    n_total++; if (cpu_rd_data !== 8'h00) begin n_bad++; $display("FAIL rst_rd got=%0h exp=0", cpu_rd_data); end
    n_total++; if (o_dbg_state !== ST_IDLE) begin n_bad++; $display("FAIL rst_state got=%0h exp=0", o_dbg_state); end
    n_total++; if (ram_a !== 19'h54321) begin n_bad++; $display("FAIL rst_ram_a got=%0h exp=54321", ram_a); end
    reset_l = 1'b1;
    tick;
  endtask

  task test_no_cs;
    mem_cs = 1'b0; bus_memw_l = 1'b0; we_cnt = 0;
    repeat (6) tick;
    n_total++; if (bus_rdy !== 1'b1) begin n_bad++; $display("FAIL nocs_rdy got=%0h exp=1", bus_rdy); end
    n_total++; if (o_dbg_state !== ST_IDLE) begin n_bad++; $display("FAIL nocs_state got=%0h exp=0", o_dbg_state); end
    bus_memw_l = 1'b1;
    repeat (3) tick;
    mem_cs = 1'b1;
    n_total++; if (we_cnt !== 0) begin n_bad++; $display("FAIL nocs_we got=%0d exp=0", we_cnt); end
  endtask

  task test_write;
    tick;
    bus_a = 15'h0010; bus_d = 8'hA5; isa_op_enable = 1'b0; disp_read = 1'b0; we_cnt = 0;
    bus_memw_l = 1'b0;
    tick;
    n_total++; if (bus_rdy !== 1'b1) begin n_bad++; $display("FAIL wr_rdy_sync got=%0h exp=1", bus_rdy); end
    tick;
    n_total++; if (bus_rdy !== 1'b0) begin n_bad++; $display("FAIL wr_rdy_start got=%0h exp=0", bus_rdy); end
    tick;
    n_total++; if (o_dbg_state !== ST_WAIT) begin n_bad++; $display("FAIL wr_wait got=%0h exp=1", o_dbg_state); end
    isa_op_enable = 1'b1;
    tick;
    isa_op_enable = 1'b0;
    n_total++; if (o_dbg_state !== ST_ACCESS) begin n_bad++; $display("FAIL wr_access got=%0h exp=2", o_dbg_state); end
    n_total++; if (ram_we_l !== 1'b0) begin n_bad++; $display("FAIL wr_we got=%0h exp=0", ram_we_l); end
    n_total++; if (ram_a !== 19'h00010) begin n_bad++; $display("FAIL wr_ram_a got=%0h exp=10", ram_a); end
    n_total++; if (ram_dout !== 8'hA5) begin n_bad++; $display("FAIL wr_dout got=%0h exp=a5", ram_dout); end
    n_total++; if (bus_rdy !== 1'b0) begin n_bad++; $display("FAIL wr_rdy_acc got=%0h exp=0", bus_rdy); end
    tick;
    n_total++; if (o_dbg_state !== ST_CAPTURE) begin n_bad++; $display("FAIL wr_capture got=%0h exp=3", o_dbg_state); end
    n_total++; if (bus_rdy !== 1'b0) begin n_bad++; $display("FAIL wr_rdy_cap got=%0h exp=0", bus_rdy); end
    tick;
    n_total++; if (bus_rdy !== 1'b1) begin n_bad++; $display("FAIL wr_rdy_done got=%0h exp=1", bus_rdy); end
    n_total++; if (we_cnt !== 1) begin n_bad++; $display("FAIL wr_we_cnt got=%0d exp=1", we_cnt); end
    bus_memw_l = 1'b1;
    repeat (4) tick;
    n_total++; if (o_dbg_state !== ST_IDLE) begin n_bad++; $display("FAIL wr_idle got=%0h exp=0", o_dbg_state); end
  endtask

  task test_read;
    tick;
    n_total++; if (cpu_rd_data !== 8'h00) begin n_bad++; $display("FAIL rd_pre got=%0h exp=0", cpu_rd_data); end
    bus_a = 15'h1234; isa_op_enable = 1'b1; we_cnt = 0;
    bus_memr_l = 1'b0;
    repeat (4) tick;
    n_total++; if (ram_a !== 19'h01234) begin n_bad++; $display("FAIL rd_ram_a got=%0h exp=1234", ram_a); end
    n_total++; if (ram_we_l !== 1'b1) begin n_bad++; $display("FAIL rd_we got=%0h exp=1", ram_we_l); end
    tick;
    n_total++; if (bus_rdy !== 1'b0) begin n_bad++; $display("FAIL rd_rdy_cap got=%0h exp=0", bus_rdy); end
    tick;
    n_total++; if (bus_rdy !== 1'b1) begin n_bad++; $display("FAIL rd_rdy_done got=%0h exp=1", bus_rdy); end
    n_total++; if (cpu_rd_data !== 8'h3C) begin n_bad++; $display("FAIL rd_data got=%0h exp=3c", cpu_rd_data); end
    bus_memr_l = 1'b1; isa_op_enable = 1'b0;
    repeat (4) tick;
    n_total++; if (cpu_rd_data !== 8'h3C) begin n_bad++; $display("FAIL rd_hold got=%0h exp=3c", cpu_rd_data); end
    n_total++; if (we_cnt !== 0) begin n_bad++; $display("FAIL rd_we_cnt got=%0d exp=0", we_cnt); end
  endtask

  task test_priority;
    int rdy_hi;
    rdy_hi = 0;
    bus_a = 15'h0020; bus_d = 8'h5A; disp_read = 1'b1; we_cnt = 0;
    bus_memw_l = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick;
      isa_op_enable = i[0];
      if (i >= 2 && bus_rdy !== 1'b0) rdy_hi++;
    end
    n_total++; if (rdy_hi !== 0) begin n_bad++; $display("FAIL pri_rdy got=%0d exp=0", rdy_hi); end
    n_total++; if (we_cnt !== 0) begin n_bad++; $display("FAIL pri_we got=%0d exp=0", we_cnt); end
    n_total++; if (o_dbg_state !== ST_WAIT) begin n_bad++; $display("FAIL pri_wait got=%0h exp=1", o_dbg_state); end
    disp_read = 1'b0; isa_op_enable = 1'b0;
    tick;
    n_total++; if (o_dbg_state !== ST_ACCESS) begin n_bad++; $display("FAIL pri_access got=%0h exp=2", o_dbg_state); end
    n_total++; if (ram_dout !== 8'h5A || ram_a !== 19'h00020) begin n_bad++; $display("FAIL pri_wr got=%0h@%0h exp=5a@20", ram_dout, ram_a); end
    tick; tick;
    n_total++; if (bus_rdy !== 1'b1) begin n_bad++; $display("FAIL pri_done got=%0h exp=1", bus_rdy); end
    bus_memw_l = 1'b1;
    repeat (4) tick;
  endtask

  task test_timeout;
    bus_a = 15'h0044; bus_d = 8'h77; disp_read = 1'b0; isa_op_enable = 1'b0;
    bus_memw_l = 1'b0;
    repeat (34) tick;
    n_total++; if (o_dbg_state !== ST_WAIT) begin n_bad++; $display("FAIL to_last_wait got=%0h exp=1", o_dbg_state); end
    tick;
    n_total++; if (o_dbg_state !== ST_ACCESS) begin n_bad++; $display("FAIL to_access got=%0h exp=2", o_dbg_state); end
    tick; tick;
    bus_memw_l = 1'b1;
    repeat (4) tick;
  endtask

  task test_abort;
    bus_a = 15'h0030; bus_d = 8'h99; we_cnt = 0;
    bus_memw_l = 1'b0;
    repeat (3) tick;
    n_total++; if (o_dbg_state !== ST_WAIT) begin n_bad++; $display("FAIL ab_wait got=%0h exp=1", o_dbg_state); end
    bus_memw_l = 1'b1;
    repeat (3) tick;
    n_total++; if (o_dbg_state !== ST_IDLE) begin n_bad++; $display("FAIL ab_idle got=%0h exp=0", o_dbg_state); end
    n_total++; if (bus_rdy !== 1'b1) begin n_bad++; $display("FAIL ab_rdy got=%0h exp=1", bus_rdy); end
    repeat (2) tick;
    n_total++; if (we_cnt !== 0) begin n_bad++; $display("FAIL ab_we got=%0d exp=0", we_cnt); end
  endtask

  task test_reset_mid;
    bus_a = 15'h0050; bus_d = 8'h11; we_cnt = 0;
    bus_memw_l = 1'b0;
    repeat (3) tick;
    n_total++; if (o_dbg_state !== ST_WAIT) begin n_bad++; $display("FAIL rm_wait got=%0h exp=1", o_dbg_state); end
    #2 reset_l = 1'b0;
    #1;
    n_total++; if (bus_rdy !== 1'b1) begin n_bad++; $display("FAIL rm_rdy got=%0h exp=1", bus_rdy); end
    n_total++; if (ram_we_l !== 1'b1) begin n_bad++; $display("FAIL rm_we got=%0h exp=1", ram_we_l); end
    n_total++; if (o_dbg_state !== ST_IDLE) begin n_bad++; $display("FAIL rm_state got=%0h exp=0", o_dbg_state); end
    bus_memw_l = 1'b1;
    tick;
    reset_l = 1'b1;
    tick;
    bus_a = 15'h0060; bus_d = 8'hC3; isa_op_enable = 1'b1; we_cnt = 0;
    bus_memw_l = 1'b0;
    repeat (6) tick;
    n_total++; if (bus_rdy !== 1'b1) begin n_bad++; $display("FAIL rm_after_rdy got=%0h exp=1", bus_rdy); end
    n_total++; if (we_cnt !== 1 || we_a !== 19'h00060 || we_d !== 8'hC3)
      begin n_bad++; $display("FAIL rm_after_wr got=%0d:%0h@%0h exp=1:c3@60", we_cnt, we_d, we_a); end
    bus_memw_l = 1'b1; isa_op_enable = 1'b0;
    repeat (4) tick;
  endtask

  task test_snow;
    bit got_rdy;
    disp_a = 19'h00077; disp_read = 1'b1; bus_a = 15'h0070; bus_d = 8'hFF; isa_op_enable = 1'b0;
    tick;
    bus_memw_l = 1'b0;
    repeat (5) tick;
`ifdef CGA_SNOW_EN
    n_total++; if (disp_d !== 8'hFF) begin n_bad++; $display("FAIL snow_ff got=%0h exp=ff", disp_d); end
`else
    n_total++; if (disp_d !== 8'h2D) begin n_bad++; $display("FAIL snow_clean got=%0h exp=2d", disp_d); end
`endif
    tick;
    n_total++; if (disp_d !== 8'h2D) begin n_bad++; $display("FAIL snow_after got=%0h exp=2d", disp_d); end
    disp_read = 1'b0;
    got_rdy = 1'b0;
    for (int i = 0; i < 50 && !got_rdy; i++) begin
      tick;
      if (bus_rdy === 1'b1) got_rdy = 1'b1;
    end
    n_total++; if (!got_rdy) begin n_bad++; $display("FAIL snow_rdy got=timeout exp=rdy"); end
    bus_memw_l = 1'b1;
    repeat (4) tick;
`ifndef CGA_SNOW_EN
    n_total++; if (disp_bad !== 0) begin n_bad++; $display("FAIL disp_pass got=%0d exp=0", disp_bad); end
`endif
  endtask

  initial begin
    reset_l = 1'b0; mem_cs = 1'b1; bus_a = '0; bus_d = '0;
    bus_memr_l = 1'b1; bus_memw_l = 1'b1;
    disp_a = 19'h54321; disp_read = 1'b0; isa_op_enable = 1'b0;
    test_reset;
    test_no_cs;
    test_write;
    test_read;
    test_priority;
    test_timeout;
    test_abort;
    test_reset_mid;
    test_snow;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
